// File: rtl/seq_bit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// seq_ser_pkg
// Shared definitions for the parallel-to-serial feeder of the sequence
// detector:
//   - ser_state_e : shifter FSM state (IDLE / SHIFT)
//   - DEFAULT_WIDTH : default word width
//   - cnt_w()     : width of the bit counter for a given word width
// -----------------------------------------------------------------------------
package seq_ser_pkg;

    // One-bit encoding.  IDLE must be the all-zero code because it is the
    // reset value and ser_valid is simply "state is SHIFT".
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam int DEFAULT_WIDTH = 8;

    // The counter runs 0..WIDTH-1, so clog2(WIDTH) bits are enough.
    // Legal widths start at 2, which keeps the result at least 1.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage : seq_ser_pkg

// File: rtl/seq_bit_serializer_if.sv
// -----------------------------------------------------------------------------
// seq_ser_if
// Bundles the word-input handshake and the serial output side of the
// serializer.
//   din        : parallel word (WIDTH bits), source -> serializer
//   din_valid  : din holds a valid word,      source -> serializer
//   din_ready  : serializer can take a word,  serializer -> source
//   ser_out    : serial bit stream,           serializer -> detector
//   ser_valid  : ser_out carries a data bit
//   word_done  : ser_out carries the last bit of a word
//   busy       : shifter or holding buffer occupied
// Modports:
//   master : the word source / observer side
//   slave  : the serializer itself
// -----------------------------------------------------------------------------
interface seq_ser_if
    import seq_ser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  ser_out,
        input  ser_valid,
        input  word_done,
        input  busy
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output ser_out,
        output ser_valid,
        output word_done,
        output busy
    );

endinterface : seq_ser_if

// File: rtl/seq_bit_serializer_hold_buf.sv
// -----------------------------------------------------------------------------
// ser_hold_buf
// One-entry holding register in front of the shifter.  It lets the next word
// be captured while the current one is still being shifted, so words can
// stream with no idle gap.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   din         : incoming parallel word
//   din_valid   : incoming word is valid
//   take        : shifter copies the held word on this edge
//   hold_data   : the held word
//   hold_full   : a word is held
//   din_ready   : buffer can accept a word (registered, no input path)
// -----------------------------------------------------------------------------
module ser_hold_buf
    import seq_ser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             take,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_full,
    output logic             din_ready
);

    logic [WIDTH-1:0] hold_reg_q;
    logic [WIDTH-1:0] hold_reg_d;
    logic             hold_full_q;
    logic             hold_full_d;
    logic             accept;

    // Ready depends only on the flop, so the source never sees a
    // combinational path back from its own valid.
    assign din_ready = !hold_full_q;
    assign accept    = din_valid && din_ready;

    always_comb begin
        hold_reg_d  = hold_reg_q;
        hold_full_d = hold_full_q;
        if (accept) begin
            // accept and take are mutually exclusive (accept needs an empty
            // buffer, take needs a full one); accept is given priority anyway
            // so a word can never be silently dropped.
            hold_reg_d  = din;
            hold_full_d = 1'b1;
        end else if (take) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg_q  <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_reg_q  <= hold_reg_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign hold_data = hold_reg_q;
    assign hold_full = hold_full_q;

endmodule : ser_hold_buf

// File: rtl/seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer
// Accepts parallel words over a valid/ready handshake and shifts them out one
// bit per clock on ser_out, feeding the serial sequence detector.  A one-entry
// holding buffer lets consecutive words stream back to back.  With nothing in
// flight ser_out sits at IDLE_LEVEL.
// Parameters:
//   WIDTH      : bits per word (2..32)
//   MSB_FIRST  : 1 = din[WIDTH-1] goes out first, 0 = din[0] goes out first
//   IDLE_LEVEL : ser_out level while no word is being shifted
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset (synchronously released
//                upstream); aborts any word in flight and empties the buffer
//   bus        : seq_ser_if slave modport (din/din_valid/din_ready in,
//                ser_out/ser_valid/word_done/busy out)
// All outputs are decoded from flops only.
// -----------------------------------------------------------------------------
module seq_bit_serializer
    import seq_ser_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic    clk,
    input  logic    rst_n,
    seq_ser_if.slave bus
);

    localparam int             CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    // -------------------------------------------------------------------------
    // Holding buffer
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic             load_sh;

    ser_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (bus.din),
        .din_valid (bus.din_valid),
        .take      (load_sh),
        .hold_data (hold_data),
        .hold_full (hold_full),
        .din_ready (bus.din_ready)
    );

    // -------------------------------------------------------------------------
    // Shifter state
    // -------------------------------------------------------------------------
    ser_state_e       state_q;
    ser_state_e       state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;

    // sh_q moved one place toward the output end, zero filled, and the bit
    // currently sitting at the output end.
    logic [WIDTH-1:0] sh_shifted;
    logic             out_bit;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign out_bit       = sh_q[WIDTH-1];
            assign sh_shifted[0] = 1'b0;
            for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
                assign sh_shifted[gi] = sh_q[gi-1];
            end
        end else begin : g_lsb_first
            assign out_bit             = sh_q[0];
            assign sh_shifted[WIDTH-1] = 1'b0;
            for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
                assign sh_shifted[gi] = sh_q[gi+1];
            end
        end
    endgenerate

    logic last_bit;
    assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    // The held word moves into the shifter either when the shifter is empty
    // or on the same edge that retires the last bit of the current word;
    // the latter is what makes back-to-back words gapless.
    assign load_sh = hold_full && ((state_q == IDLE) || last_bit);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        if (load_sh) begin
            sh_d    = hold_data;
            cnt_d   = '0;
            state_d = SHIFT;
        end else if (state_q == SHIFT) begin
            if (cnt_q == CNT_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
                sh_d  = sh_shifted;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode (flops only; reset drives ser_out to IDLE_LEVEL at once
    // because state_q clears asynchronously)
    // -------------------------------------------------------------------------
    assign bus.ser_out   = (state_q == SHIFT) ? out_bit : IDLE_LEVEL;
    assign bus.ser_valid = (state_q == SHIFT);
    assign bus.word_done = last_bit;
    assign bus.busy      = (state_q == SHIFT) || hold_full;

endmodule : seq_bit_serializer
